// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer
// Function : Runs an in-place radix-2 DIT FFT over a dual-port data RAM, one
//            butterfly per clock, around an external combinational butterfly.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
    parameter int MAX_LOG2N = 10,
    parameter int ADDR_W    = MAX_LOG2N,
    parameter int TW_ADDR_W = MAX_LOG2N - 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [3:0]           i_log2n,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_en,
    output logic [ADDR_W-1:0]    o_rd_addr_1,
    output logic [ADDR_W-1:0]    o_rd_addr_2,
    input  logic [31:0]          i_rd_data_1,
    input  logic [31:0]          i_rd_data_2,
    output logic                 o_tw_rd_en,
    output logic [TW_ADDR_W-1:0] o_tw_addr,
    input  logic [31:0]          i_tw_data,
    output logic                 o_bf_valid,
    output logic [31:0]          o_bf_di_1,
    output logic [31:0]          o_bf_di_2,
    output logic [31:0]          o_bf_w,
    input  logic                 i_bf_valid,
    input  logic [31:0]          i_bf_do_1,
    input  logic [31:0]          i_bf_do_2,
    output logic                 o_wr_en,
    output logic [ADDR_W-1:0]    o_wr_addr_1,
    output logic [ADDR_W-1:0]    o_wr_addr_2,
    output logic [31:0]          o_wr_data_1,
    output logic [31:0]          o_wr_data_2
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [3:0] c_max_log2n = 4'(MAX_LOG2N);
    localparam logic [3:0] c_tw_top    = 4'(MAX_LOG2N - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_log2n;
    logic [3:0]        r_stage;
    logic [ADDR_W-1:0] r_k;
    logic              r_drain;
    logic [ADDR_W-1:0] r_addr_1_d;
    logic [ADDR_W-1:0] r_addr_2_d;

    logic                 w_rd_en;
    logic                 w_start_ok;
    logic [ADDR_W-1:0]    w_half;
    logic [ADDR_W-1:0]    w_pos;
    logic [ADDR_W-1:0]    w_grp;
    logic [ADDR_W-1:0]    w_addr_1;
    logic [ADDR_W-1:0]    w_addr_2;
    logic [ADDR_W-1:0]    w_k_max;
    logic [TW_ADDR_W-1:0] w_tw_addr;

    // Butterfly k of stage s pairs (grp*2*half + pos) with its partner half away.
    always_comb begin
        w_half    = ADDR_W'(1) << r_stage;
        w_pos     = r_k & (w_half - ADDR_W'(1));
        w_grp     = r_k >> r_stage;
        w_addr_1  = (w_grp << (r_stage + 4'd1)) | w_pos;
        w_addr_2  = w_addr_1 + w_half;
        w_k_max   = (ADDR_W'(1) << (r_log2n - 4'd1)) - ADDR_W'(1);
        w_tw_addr = TW_ADDR_W'(w_pos) << (c_tw_top - r_stage);
    end

    assign w_rd_en    = (r_state == c_st_run);
    assign w_start_ok = i_start && (i_log2n != 4'd0) && (i_log2n <= c_max_log2n);

    assign o_busy      = (r_state == c_st_run) || (r_state == c_st_drain);
    assign o_rd_en     = w_rd_en;
    assign o_tw_rd_en  = w_rd_en;
    assign o_rd_addr_1 = w_rd_en ? w_addr_1 : '0;
    assign o_rd_addr_2 = w_rd_en ? w_addr_2 : '0;
    assign o_tw_addr   = w_rd_en ? w_tw_addr : '0;
    assign o_bf_di_1   = i_rd_data_1;
    assign o_bf_di_2   = i_rd_data_2;
    assign o_bf_w      = i_tw_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_st_idle;
            r_log2n     <= 4'd0;
            r_stage     <= 4'd0;
            r_k         <= '0;
            r_drain     <= 1'b0;
            r_addr_1_d  <= '0;
            r_addr_2_d  <= '0;
            o_done      <= 1'b0;
            o_bf_valid  <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr_1 <= '0;
            o_wr_addr_2 <= '0;
            o_wr_data_1 <= '0;
            o_wr_data_2 <= '0;
        end else begin
            o_done     <= 1'b0;
            o_bf_valid <= w_rd_en;
            r_addr_1_d <= w_addr_1;
            r_addr_2_d <= w_addr_2;
            // A butterfly that reports invalid simply loses its write slot.
            o_wr_en    <= o_bf_valid & i_bf_valid;
            if (o_bf_valid) begin
                o_wr_data_1 <= i_bf_do_1;
                o_wr_data_2 <= i_bf_do_2;
                o_wr_addr_1 <= r_addr_1_d;
                o_wr_addr_2 <= r_addr_2_d;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_start_ok) begin
                        r_log2n <= i_log2n;
                        r_stage <= 4'd0;
                        r_k     <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (r_k == w_k_max) begin
                        r_k     <= '0;
                        r_drain <= 1'b0;
                        r_state <= c_st_drain;
                    end else begin
                        r_k <= r_k + ADDR_W'(1);
                    end
                end
                c_st_drain: begin
                    // Two idle cycles let the stage's last write land before the next read.
                    if (r_drain) begin
                        if (r_stage < (r_log2n - 4'd1)) begin
                            r_stage <= r_stage + 4'd1;
                            r_state <= c_st_run;
                        end else begin
                            r_state <= c_st_done;
                        end
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                c_st_done: begin
                    o_done  <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
